// File: rtl/dram_miss_master.sv
// dram_miss_master: memory-side initiator for the data cache.
// Takes one miss at a time from the cache controller, runs an optional
// dirty-line writeback (SW) then a refill read (LW) on the DRAM port, and
// returns the refill word to the controller as a one-cycle fill pulse.
// Optional feature macro: DRAM_TIMEOUT_EN. It bounds the wait for mem_ready
// and reports an expired wait through fill_err.
module dram_miss_master #(
  parameter int tag     = 20,
  parameter int data    = 11,
  parameter int TIMEOUT = 16,
  localparam int LINE_W = tag + data + 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              miss_valid,
  output logic              miss_ready,
  input  logic [31:0]       miss_addr,
  input  logic              miss_dirty,
  input  logic [31:0]       wb_addr,
  input  logic [LINE_W-1:0] wb_line,
  output logic              fill_valid,
  output logic [data-1:0]   fill_data,
  output logic              fill_err,
  output logic [31:0]       mem_address,
  output logic              lsu_operator,
  output logic              mem_req,
  output logic [LINE_W-1:0] write_data_int,
  input  logic              mem_ready,
  input  logic [data-1:0]   dram_data_out
);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    WB_REQ  = 3'd1,
    RD_REQ  = 3'd2,
    RD_WAIT = 3'd3,
    RESP    = 3'd4
  } state_t;

  state_t      state_r;
  logic [31:0] miss_addr_r;
  logic        timeout_hit_s;

`ifdef DRAM_TIMEOUT_EN
  localparam logic [7:0] TIMEOUT_LAST = 8'(TIMEOUT - 1);

  logic [7:0] timer_r;

  // Wait-cycle counter: cleared on entry to each request state, counts stalled cycles there.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      timer_r <= 8'd0;
    end else if ((state_r == IDLE) && miss_valid) begin
      timer_r <= 8'd0;
    end else if ((state_r == WB_REQ) && mem_ready) begin
      timer_r <= 8'd0;
    end else if (((state_r == WB_REQ) || (state_r == RD_REQ)) && !mem_ready) begin
      timer_r <= timer_r + 8'd1;
    end else begin
      timer_r <= timer_r;
    end
  end

  // The wait expires on the edge that would bring the counter up to TIMEOUT.
  always_comb begin
    timeout_hit_s = 1'b0;
    if (timer_r == TIMEOUT_LAST) begin
      timeout_hit_s = 1'b1;
    end else begin
      timeout_hit_s = 1'b0;
    end
  end
`else
  // Without the timeout feature the block waits for mem_ready indefinitely.
  always_comb begin
    timeout_hit_s = 1'b0;
  end
`endif

  // Miss sequencer; every output is a register updated alongside the state.
  // mem_address / write_data_int double as the latched writeback address and
  // line, so only the refill address needs its own holding register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r        <= IDLE;
      miss_addr_r    <= 32'd0;
      miss_ready     <= 1'b1;
      mem_req        <= 1'b0;
      lsu_operator   <= 1'b0;
      mem_address    <= 32'd0;
      write_data_int <= '0;
      fill_valid     <= 1'b0;
      fill_data      <= '0;
      fill_err       <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          if (miss_valid) begin
            miss_addr_r <= miss_addr;
            miss_ready  <= 1'b0;
            mem_req     <= 1'b1;
            if (miss_dirty) begin
              state_r        <= WB_REQ;
              lsu_operator   <= 1'b1;
              mem_address    <= wb_addr;
              write_data_int <= wb_line;
            end else begin
              state_r      <= RD_REQ;
              lsu_operator <= 1'b0;
              mem_address  <= miss_addr;
            end
          end else begin
            state_r <= IDLE;
          end
        end

        WB_REQ: begin
          if (mem_ready) begin
            state_r      <= RD_REQ;
            lsu_operator <= 1'b0;
            mem_address  <= miss_addr_r;
          end else if (timeout_hit_s) begin
            // Abandon the writeback and skip the read altogether.
            state_r    <= RESP;
            mem_req    <= 1'b0;
            fill_valid <= 1'b1;
            fill_err   <= 1'b1;
            fill_data  <= '0;
          end else begin
            state_r <= WB_REQ;
          end
        end

        RD_REQ: begin
          if (mem_ready) begin
            state_r <= RD_WAIT;
            mem_req <= 1'b0;
          end else if (timeout_hit_s) begin
            state_r    <= RESP;
            mem_req    <= 1'b0;
            fill_valid <= 1'b1;
            fill_err   <= 1'b1;
            fill_data  <= '0;
          end else begin
            state_r <= RD_REQ;
          end
        end

        RD_WAIT: begin
          // Read data is valid in the cycle after the accepting edge.
          state_r    <= RESP;
          fill_data  <= dram_data_out;
          fill_valid <= 1'b1;
          fill_err   <= 1'b0;
        end

        RESP: begin
          state_r    <= IDLE;
          fill_valid <= 1'b0;
          fill_err   <= 1'b0;
          miss_ready <= 1'b1;
        end

        default: begin
          state_r    <= IDLE;
          mem_req    <= 1'b0;
          fill_valid <= 1'b0;
          fill_err   <= 1'b0;
          miss_ready <= 1'b1;
        end
      endcase
    end
  end

endmodule
